// File: rtl/mem_wb_queue.sv
// MEM->WB writeback queue: a DEPTH-entry circular buffer of multi-lane register
// write bundles with valid/ready on both sides, flush, x0 suppression and rdy freeze.
module mem_wb_queue #(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 5,
    parameter int LANES         = 1,
    parameter int DEPTH         = 2,
    parameter int ZERO_SUPPRESS = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*DATA_W-1:0]   in_rd_data,
    input  logic [LANES*ADDR_W-1:0]   in_rd_addr,
    input  logic [LANES-1:0]          in_rd_en,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*DATA_W-1:0]   wb_rd_data,
    output logic [LANES*ADDR_W-1:0]   wb_rd_addr,
    output logic [LANES-1:0]          wb_rd_enable,
    output logic [$clog2(DEPTH):0]    occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [LANES*DATA_W-1:0] data;
        logic [LANES*ADDR_W-1:0] addr;
        logic [LANES-1:0]        en;
    } bundle_t;

    bundle_t          mem_q [DEPTH];
    bundle_t          head;
    logic [PTR_W-1:0] wp_q, wp_d;
    logic [PTR_W-1:0] rp_q, rp_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push;
    logic             pop;

    // Handshake flags come from registered count only, so in_ready never sees out_ready.
    assign in_ready  = (count_q < CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign occupancy = count_q;

    assign push = rdy && in_valid && in_ready && !flush;
    assign pop  = rdy && out_valid && out_ready && !flush;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        if (rdy) begin
            if (flush) begin
                wp_d    = '0;
                rp_d    = '0;
                count_d = '0;
            end else begin
                if (push) wp_d = wp_q + 1'b1;
                if (pop)  rp_d = rp_q + 1'b1;
                if (push && !pop)      count_d = count_q + 1'b1;
                else if (!push && pop) count_d = count_q - 1'b1;
            end
        end
    end

    // NOTE: storage is cleared on reset so a stale entry can never surface on wb_*.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            if (push) mem_q[wp_q] <= '{data: in_rd_data, addr: in_rd_addr, en: in_rd_en};
        end
    end

    assign head = mem_q[rp_q];

    always_comb begin
        wb_rd_data   = '0;
        wb_rd_addr   = '0;
        wb_rd_enable = '0;
        if (out_valid) begin
            wb_rd_data = head.data;
            wb_rd_addr = head.addr;
            for (int i = 0; i < LANES; i++) begin
                wb_rd_enable[i] = head.en[i] &&
                    !((ZERO_SUPPRESS != 0) && (head.addr[i*ADDR_W +: ADDR_W] == '0));
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_queue.sv
// Randomised and directed bench for mem_wb_queue against a queue-based model of
// the writeback buffer's behaviour.
module tb_mem_wb_queue;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int LANES  = 2;
    localparam int DEPTH  = 2;

    typedef struct {
        logic [LANES*DATA_W-1:0] data;
        logic [LANES*ADDR_W-1:0] addr;
        logic [LANES-1:0]        en;
    } bundle_t;

    logic                    clk = 1'b0;
    logic                    rst, rdy, flush, in_valid, out_ready;
    logic                    in_ready, out_valid;
    logic [LANES*DATA_W-1:0] in_rd_data, wb_rd_data;
    logic [LANES*ADDR_W-1:0] in_rd_addr, wb_rd_addr;
    logic [LANES-1:0]        in_rd_en, wb_rd_enable;
    logic [$clog2(DEPTH):0]  occupancy;

    bundle_t model_q[$];
    int      n_tests = 0;
    int      n_fail  = 0;
    bit      check_en = 1'b0;

    mem_wb_queue #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANES(LANES), .DEPTH(DEPTH), .ZERO_SUPPRESS(1)
    ) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rd_data(in_rd_data), .in_rd_addr(in_rd_addr), .in_rd_en(in_rd_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .wb_rd_data(wb_rd_data), .wb_rd_addr(wb_rd_addr), .wb_rd_enable(wb_rd_enable),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_bundle(input logic [LANES-1:0] en,
                              input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                              input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
        in_rd_en   = en;
        in_rd_addr = {a1, a0};
        in_rd_data = {d1, d0};
    endtask

    // Compare outputs against the model, then advance the model over the coming edge.
    task automatic tick();
        logic [63:0]      ed, ea;
        logic [LANES-1:0] ee;
        bit               do_push, do_pop;
        bundle_t          b;
        ed = '0; ea = '0; ee = '0;
        if (model_q.size() > 0) begin
            ed = 64'(model_q[0].data);
            ea = 64'(model_q[0].addr);
            for (int i = 0; i < LANES; i++)
                ee[i] = model_q[0].en[i] && (model_q[0].addr[i*ADDR_W +: ADDR_W] != 0);
        end
        if (check_en) begin
            check("out_valid", 64'(out_valid), 64'(model_q.size() != 0));
            check("in_ready", 64'(in_ready), 64'(model_q.size() < DEPTH));
            check("occupancy", 64'(occupancy), 64'(model_q.size()));
            check("wb_rd_data", 64'(wb_rd_data), ed);
            check("wb_rd_addr", 64'(wb_rd_addr), ea);
            check("wb_rd_enable", 64'(wb_rd_enable), 64'(ee));
        end
        if (!rst) begin
            model_q.delete();
        end else if (rdy) begin
            if (flush) begin
                model_q.delete();
            end else begin
                do_push = in_valid && (model_q.size() < DEPTH);
                do_pop  = out_ready && (model_q.size() > 0);
                if (do_pop) void'(model_q.pop_front());
                if (do_push) begin
                    b.data = in_rd_data; b.addr = in_rd_addr; b.en = in_rd_en;
                    model_q.push_back(b);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_en = 1'b1;
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        set_bundle(2'b11, 5'd1, 32'h1, 5'd2, 32'h2);
        @(negedge clk);

        // Reset held for two cycles with in_valid high.
        tick(); tick();
        rst = 1'b1; in_valid = 1'b0;
        tick();
        check("reset_occ", 64'(occupancy), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);

        // Streaming with out_ready held high.
        out_ready = 1'b1; in_valid = 1'b1;
        set_bundle(2'b11, 5'd3, 32'h11, 5'd7, 32'h22);
        tick();
        set_bundle(2'b11, 5'd4, 32'h33, 5'd8, 32'h44);
        tick();
        in_valid = 1'b0;
        tick(); tick();

        // Backpressure: third bundle held until a slot frees.
        out_ready = 1'b0; in_valid = 1'b1;
        set_bundle(2'b01, 5'd9, 32'hA1, 5'd10, 32'hA2);  tick();
        set_bundle(2'b10, 5'd11, 32'hB1, 5'd12, 32'hB2); tick();
        set_bundle(2'b11, 5'd13, 32'hC1, 5'd14, 32'hC2); tick();
        check("bp_full_in_ready", 64'(in_ready), 64'd0);
        tick();
        out_ready = 1'b1;
        tick(); tick();
        in_valid = 1'b0;
        tick(); tick(); tick();

        // x0 suppression on lane 0.
        in_valid = 1'b1; out_ready = 1'b0;
        set_bundle(2'b11, 5'd0, 32'hDEAD, 5'd5, 32'hBEEF);
        tick();
        in_valid = 1'b0;
        check("x0_enable", 64'(wb_rd_enable), 64'b10);
        check("x0_data", 64'(wb_rd_data), {32'hBEEF, 32'hDEAD});
        tick();

        // Flush of a full queue beats a simultaneous push and pop.
        in_valid = 1'b1;
        set_bundle(2'b11, 5'd6, 32'h66, 5'd7, 32'h77);
        tick();
        flush = 1'b1; out_ready = 1'b1;
        set_bundle(2'b11, 5'd8, 32'h88, 5'd9, 32'h99);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_occ", 64'(occupancy), 64'd0);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        tick();

        // rdy freeze with one bundle stored.
        in_valid = 1'b1; out_ready = 1'b0;
        set_bundle(2'b11, 5'd12, 32'h1234, 5'd13, 32'h5678);
        tick();
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = i[0]; out_ready = ~i[0];
            set_bundle(2'b11, 5'd20, 32'hF0F0, 5'd21, 32'h0F0F);
            tick();
        end
        check("freeze_occ", 64'(occupancy), 64'd1);
        rdy = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        tick();

        // Randomised traffic.
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(99) != 0);
            rdy       = ($urandom_range(9) != 0);
            flush     = ($urandom_range(19) == 0);
            in_valid  = ($urandom_range(9) < 6);
            out_ready = ($urandom_range(9) < 6);
            in_rd_en   = LANES'($urandom);
            in_rd_addr = {ADDR_W'($urandom_range(3)), ADDR_W'($urandom_range(3))};
            in_rd_data = {32'($urandom), 32'($urandom)};
            tick();
        end

        rst = 1'b1; rdy = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
